// File: rtl/apu_pkg.sv
// apu_pkg -- shared types and step tables for the APU frame sequencer.
// Mode encoding matches the control-register bit: 0 = 4-step, 1 = 5-step.
// Step tables are indexed by step number; bit N is the pulse for step N.
package apu_pkg;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } mode_e;

  // Number of step slots covered by the tables (steps 0..4)
  localparam int STEP_SLOTS = 5;

  // 4-step mode: quarter on steps 0-3, half on steps 1 and 3
  localparam logic [STEP_SLOTS-1:0] QUARTER_4STEP = 5'b01111;
  localparam logic [STEP_SLOTS-1:0] HALF_4STEP    = 5'b01010;

  // 5-step mode: quarter on steps 0,1,2,4, half on steps 1 and 4, step 3 silent
  localparam logic [STEP_SLOTS-1:0] QUARTER_5STEP = 5'b10111;
  localparam logic [STEP_SLOTS-1:0] HALF_5STEP    = 5'b10010;

  // Last step index before wrapping back to 0 in the given mode
  function automatic logic [2:0] last_step(input mode_e mode);
    return (mode == MODE_5STEP) ? 3'd4 : 3'd3;
  endfunction

  // Table lookup that treats any index beyond the table as "no pulse"
  function automatic logic table_bit(input logic [STEP_SLOTS-1:0] tbl,
                                     input logic [2:0]            idx);
    return (idx < 3'(STEP_SLOTS)) ? tbl[idx] : 1'b0;
  endfunction

endpackage

// File: rtl/apu_frame_seq.sv
// apu_frame_seq -- APU frame sequencer.
// Counts divider ticks through a 4- or 5-step frame and emits registered
// quarter/half-frame pulses plus a level frame interrupt.
// Optional feature: define APU_FRAME_IRQ_EN to build the frame IRQ logic;
// without it irq is tied low and inhibit_in/irq_ack are ignored.
module apu_frame_seq
  import apu_pkg::*;
#(
  parameter int BITS = 3
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            tick,
  input  logic            wr,
  input  logic            mode_in,
  input  logic            inhibit_in,
  input  logic            irq_ack,
  output logic            quarter,
  output logic            half,
  output logic            irq,
  output logic [BITS-1:0] step
);

  // Registered state and its next-state values
  mode_e           mode_q,    mode_d;
  logic [BITS-1:0] step_q,    step_d;
  logic            quarter_q, quarter_d;
  logic            half_q,    half_d;

  // Decode of the step currently held
  logic [2:0] stepIdx;
  logic       stepInRange;
  logic       atLastStep;
  logic       stepQuarter;
  logic       stepHalf;

  // Look up what the held step should produce if a tick arrives now
  always_comb begin
    stepIdx     = step_q[2:0];
    stepInRange = (step_q < BITS'(STEP_SLOTS));
    atLastStep  = (step_q >= BITS'(last_step(mode_q)));
    stepQuarter = 1'b0;
    stepHalf    = 1'b0;
    if (stepInRange) begin
      if (mode_q == MODE_5STEP) begin
        stepQuarter = table_bit(QUARTER_5STEP, stepIdx);
        stepHalf    = table_bit(HALF_5STEP,    stepIdx);
      end else begin
        stepQuarter = table_bit(QUARTER_4STEP, stepIdx);
        stepHalf    = table_bit(HALF_4STEP,    stepIdx);
      end
    end
  end

  // Next-state for mode, step and pulses; a write beats a coincident tick
  always_comb begin
    mode_d    = mode_q;
    step_d    = step_q;
    quarter_d = 1'b0;
    half_d    = 1'b0;
    if (wr) begin
      mode_d    = mode_e'(mode_in);
      step_d    = '0;
      quarter_d = mode_in;
      half_d    = mode_in;
    end else if (tick) begin
      quarter_d = stepQuarter;
      half_d    = stepHalf;
      step_d    = atLastStep ? '0 : step_q + BITS'(1);
    end
  end

`ifdef APU_FRAME_IRQ_EN
  logic inhibit_q, inhibit_d;
  logic irq_q,     irq_d;
  logic irqSet;

  // Frame IRQ: set on a step-3 tick in 4-step mode, set wins over ack
  always_comb begin
    inhibit_d = inhibit_q;
    irq_d     = irq_q & ~irq_ack;
    irqSet    = 1'b0;
    if (wr) begin
      inhibit_d = inhibit_in;
      if (inhibit_in) begin
        irq_d = 1'b0;
      end
    end else if (tick) begin
      irqSet = (mode_q == MODE_4STEP) && (step_q == BITS'(3)) && !inhibit_q;
      if (irqSet) begin
        irq_d = 1'b1;
      end
    end
  end

  // Sequencer state register, cleared asynchronously on reset
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mode_q    <= MODE_4STEP;
      step_q    <= '0;
      quarter_q <= 1'b0;
      half_q    <= 1'b0;
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      step_q    <= step_d;
      quarter_q <= quarter_d;
      half_q    <= half_d;
      inhibit_q <= inhibit_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  // The IRQ inputs have no function in this build
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{inhibit_in, irq_ack};

  // Sequencer state register, cleared asynchronously on reset
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mode_q    <= MODE_4STEP;
      step_q    <= '0;
      quarter_q <= 1'b0;
      half_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      step_q    <= step_d;
      quarter_q <= quarter_d;
      half_q    <= half_d;
    end
  end

  assign irq = 1'b0;
`endif

  assign quarter = quarter_q;
  assign half    = half_q;
  assign step    = step_q;

endmodule

// File: tb/tb_apu_frame_seq.sv
// tb_apu_frame_seq -- self-checking bench for apu_frame_seq.
// Directed frame scenarios plus a randomized run against a behavioural model.
// Honours APU_FRAME_IRQ_EN: with it undefined, irq is expected to stay 0.
module tb_apu_frame_seq;

`ifdef APU_FRAME_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic       clk;
  logic       n_reset;
  logic       tick;
  logic       wr;
  logic       mode_in;
  logic       inhibit_in;
  logic       irq_ack;
  logic       quarter;
  logic       half;
  logic       irq;
  logic [2:0] step;

  int testsRun  = 0;
  int failCount = 0;

  // Behavioural model state
  int mStep;
  bit mMode;
  bit mInh;
  bit mIrq;
  bit mQ;
  bit mH;

  apu_frame_seq #(.BITS(3)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .tick       (tick),
    .wr         (wr),
    .mode_in    (mode_in),
    .inhibit_in (inhibit_in),
    .irq_ack    (irq_ack),
    .quarter    (quarter),
    .half       (half),
    .irq        (irq),
    .step       (step)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model reset: everything back to power-on values
  task automatic modelReset();
    mStep = 0; mMode = 0; mInh = 0; mIrq = 0; mQ = 0; mH = 0;
  endtask

  // Model one clock edge straight from the frame rules
  task automatic modelUpdate(input bit t, input bit w, input bit m,
                             input bit i, input bit a);
    int s;
    if (w) begin
      mMode = m; mInh = i; mStep = 0; mQ = m; mH = m;
      if (i || a) mIrq = 0;
    end else if (t) begin
      s = mStep;
      if (!mMode) begin
        mQ = 1;
        mH = (s == 1 || s == 3);
      end else begin
        mQ = (s != 3);
        mH = (s == 1 || s == 4);
      end
      mIrq  = (IrqEn && !mMode && s == 3 && !mInh) || (mIrq && !a);
      mStep = (s + 1) % (mMode ? 5 : 4);
    end else begin
      mQ = 0; mH = 0;
      mIrq = mIrq && !a;
    end
  endtask

  // Drive one cycle's inputs from a negedge, clear them after the edge
  task automatic applyStimulus(input bit t, input bit w, input bit m,
                               input bit i, input bit a);
    tick = t; wr = w; mode_in = m; inhibit_in = i; irq_ack = a;
    @(posedge clk);
    modelUpdate(t, w, m, i, a);
    #1;
    tick = 0; wr = 0; mode_in = 0; inhibit_in = 0; irq_ack = 0;
    @(negedge clk);
  endtask

  // Synchronous-looking reset sequence used to start each scenario
  task automatic applyReset();
    tick = 0; wr = 0; mode_in = 0; inhibit_in = 0; irq_ack = 0;
    n_reset = 0;
    modelReset();
    repeat (2) @(negedge clk);
    n_reset = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick = 0; wr = 0; mode_in = 0; inhibit_in = 0; irq_ack = 0;
    n_reset = 1;
    @(negedge clk);
    n_reset = 0;
    modelReset();
    #1;
    testsRun++;
    if ({quarter, half, irq, step} !== 6'b000_000) begin
      failCount++;
      $display("[TB] FAIL reset_outputs got q=%b h=%b irq=%b step=%0d want all 0",
               quarter, half, irq, step);
    end
    @(negedge clk);
    n_reset = 1;
    @(negedge clk);
    testsRun++;
    if ({quarter, half, irq, step} !== 6'b000_000) begin
      failCount++;
      $display("[TB] FAIL reset_release got q=%b h=%b irq=%b step=%0d want all 0",
               quarter, half, irq, step);
    end
  endtask

  task automatic test_four_step();
    bit       expH;
    bit       expIrq;
    bit [2:0] expStep;
    applyReset();
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      expH    = (k % 2 == 0);
      expIrq  = IrqEn && (k >= 4);
      expStep = 3'(k % 4);
      testsRun++;
      if ({quarter, half, irq, step} !== {1'b1, expH, expIrq, expStep}) begin
        failCount++;
        $display("[TB] FAIL four_step_tick%0d got q=%b h=%b irq=%b step=%0d want q=1 h=%b irq=%b step=%0d",
                 k, quarter, half, irq, step, expH, expIrq, expStep);
      end
    end
    applyStimulus(0, 0, 0, 0, 0);
    testsRun++;
    if ({quarter, half} !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL four_step_idle got q=%b h=%b want q=0 h=0", quarter, half);
    end
  endtask

  task automatic test_five_step();
    bit       expQ;
    bit       expH;
    bit [2:0] expStep;
    applyReset();
    applyStimulus(0, 1, 1, 1, 0);
    testsRun++;
    if ({quarter, half, irq, step} !== 6'b110_000) begin
      failCount++;
      $display("[TB] FAIL five_step_wr got q=%b h=%b irq=%b step=%0d want q=1 h=1 irq=0 step=0",
               quarter, half, irq, step);
    end
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      expQ    = (k != 4);
      expH    = (k == 2 || k == 5);
      expStep = 3'(k % 5);
      testsRun++;
      if ({quarter, half, irq, step} !== {expQ, expH, 1'b0, expStep}) begin
        failCount++;
        $display("[TB] FAIL five_step_tick%0d got q=%b h=%b irq=%b step=%0d want q=%b h=%b irq=0 step=%0d",
                 k, quarter, half, irq, step, expQ, expH, expStep);
      end
    end
  endtask

  task automatic test_irq_ack();
    applyReset();
    applyStimulus(0, 1, 0, 0, 0);
    repeat (4) applyStimulus(1, 0, 0, 0, 0);
    testsRun++;
    if (irq !== IrqEn) begin
      failCount++;
      $display("[TB] FAIL irq_set got irq=%b want %b", irq, IrqEn);
    end
    repeat (3) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1);
    testsRun++;
    if ({irq, step} !== {IrqEn, 3'd0}) begin
      failCount++;
      $display("[TB] FAIL irq_ack_vs_set got irq=%b step=%0d want irq=%b step=0", irq, step, IrqEn);
    end
    applyStimulus(0, 0, 0, 0, 1);
    testsRun++;
    if (irq !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL irq_ack_clear got irq=%b want 0", irq);
    end
  endtask

  task automatic test_wr_tick();
    applyReset();
    repeat (2) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    testsRun++;
    if ({quarter, half, step} !== 5'b00_000) begin
      failCount++;
      $display("[TB] FAIL wr_tick_collide got q=%b h=%b step=%0d want q=0 h=0 step=0", quarter, half, step);
    end
    applyStimulus(1, 0, 0, 0, 0);
    testsRun++;
    if ({quarter, half, step} !== 5'b10_001) begin
      failCount++;
      $display("[TB] FAIL wr_tick_next got q=%b h=%b step=%0d want q=1 h=0 step=1", quarter, half, step);
    end
  endtask

  task automatic test_async_reset();
    applyReset();
    repeat (7) applyStimulus(1, 0, 0, 0, 0);
    testsRun++;
    if ({irq, step} !== {IrqEn, 3'd3}) begin
      failCount++;
      $display("[TB] FAIL async_pre got irq=%b step=%0d want irq=%b step=3", irq, step, IrqEn);
    end
    #2;
    n_reset = 0;
    modelReset();
    #1;
    testsRun++;
    if ({quarter, half, irq, step} !== 6'b000_000) begin
      failCount++;
      $display("[TB] FAIL async_reset got q=%b h=%b irq=%b step=%0d want all 0", quarter, half, irq, step);
    end
    @(negedge clk);
    n_reset = 1;
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 0);
    testsRun++;
    if ({quarter, half, irq, step} !== 6'b100_001) begin
      failCount++;
      $display("[TB] FAIL async_first_tick got q=%b h=%b irq=%b step=%0d want q=1 h=0 irq=0 step=1",
               quarter, half, irq, step);
    end
  endtask

  task automatic test_random();
    bit t, w, m, i, a;
    applyReset();
    for (int n = 0; n < 400; n++) begin
      t = ($urandom_range(0, 99) < 55);
      w = ($urandom_range(0, 99) < 6);
      m = $urandom_range(0, 1) == 1;
      i = ($urandom_range(0, 99) < 30);
      a = ($urandom_range(0, 99) < 10);
      applyStimulus(t, w, m, i, a);
      testsRun++;
      if ({quarter, half, irq, step} !== {mQ, mH, mIrq, 3'(mStep)}) begin
        failCount++;
        $display("[TB] FAIL random_cycle%0d got q=%b h=%b irq=%b step=%0d want q=%b h=%b irq=%b step=%0d",
                 n, quarter, half, irq, step, mQ, mH, mIrq, mStep);
      end
    end
  endtask

  initial begin
    n_reset = 0;
    tick = 0; wr = 0; mode_in = 0; inhibit_in = 0; irq_ack = 0;
    modelReset();
    repeat (2) @(negedge clk);
    test_reset();
    test_four_step();
    test_five_step();
    test_irq_ack();
    test_wr_tick();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
